// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: shared constants, controller state encoding and write-back buffer entry type
package cache_mem_pkg;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 3;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, RESP, FWD, DRAIN, FLUSH} state_t;
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wbb_entry_t;
endpackage

// File: rtl/cache_mem_ctrl_wb_buffer.sv
// wb_buffer: circular FIFO of dirty victims with a combinational youngest-match lookup
module wb_buffer
    import cache_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [DEF_ADDR_W-1:0]      push_addr,
    input  logic [DEF_DATA_W-1:0]      push_data,
    input  logic                       pop,
    output logic [DEF_ADDR_W-1:0]      head_addr,
    output logic [DEF_DATA_W-1:0]      head_data,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [DEF_ADDR_W-1:0]      match_addr,
    output logic                       hit,
    output logic [DEF_DATA_W-1:0]      hit_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    wbb_entry_t entries [DEPTH];
    logic [PW-1:0] hd, tl;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hd    <= '0;
            tl    <= '0;
            count <= '0;
        end else begin
            if (push) tl <= tl + 1'b1;
            if (pop) hd <= hd + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clock) begin
        if (push) entries[tl] <= '{push_addr, push_data};
    end
    assign head_addr = entries[hd].addr;
    assign head_data = entries[hd].data;
    // scan oldest to youngest so the last hit wins; an entry being pushed is youngest of all
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && entries[hd + PW'(i)].addr == match_addr) begin
                hit      = 1'b1;
                hit_data = entries[hd + PW'(i)].data;
            end
        end
        if (push && push_addr == match_addr) begin
            hit      = 1'b1;
            hit_data = push_data;
        end
    end
endmodule

// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: cache refill/write-back controller; WBB_FWD_EN serves buffered victims
// directly on a refill hit, otherwise the buffer is flushed before the read.
module cache_mem_ctrl
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int WBB_DEPTH = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic                        req_wb,
    input  logic [ADDR_W-1:0]           req_wb_addr,
    input  logic [DATA_W-1:0]           req_wb_data,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_wren,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [$clog2(WBB_DEPTH):0]  wbb_count
);
    localparam int CW = $clog2(WBB_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(WBB_DEPTH);
`ifdef WBB_FWD_EN
    localparam state_t HIT_ST = FWD;
`else
    localparam state_t HIT_ST = FLUSH;
`endif
    state_t state, nxt;
    logic accept, push, pop, hit;
    logic [ADDR_W-1:0] addr_q, head_addr;
    logic [DATA_W-1:0] head_data, hit_data;
    assign req_ready = state == IDLE && wbb_count != FULL && reset_n;
    assign accept    = req_valid && req_ready;
    assign push      = accept && req_wb;
    wb_buffer #(.DEPTH(WBB_DEPTH)) u_wbb (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_addr  (req_wb_addr),
        .push_data  (req_wb_data),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (wbb_count),
        .match_addr (req_addr),
        .hit        (hit),
        .hit_data   (hit_data)
    );
    always_comb begin
        nxt = state;
        pop = 1'b0;
        case (state)
            IDLE: begin
                if (accept) nxt = hit ? HIT_ST : RD_ADDR;
                else if (|wbb_count && (!req_valid || wbb_count == FULL)) begin
                    nxt = DRAIN;
                    pop = 1'b1;
                end
            end
            RD_ADDR: nxt = RD_WAIT;
            RD_WAIT: nxt = RESP;
            FLUSH: begin
                if (|wbb_count) pop = 1'b1;
                else nxt = RD_ADDR;
            end
            default: nxt = IDLE;
        endcase
    end
    // outputs are registered from the upcoming state so they line up with it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            mem_wren  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= nxt;
            rsp_valid <= nxt == RESP || nxt == FWD;
            mem_wren  <= pop;
            if (accept) addr_q <= req_addr;
            if (state == RD_WAIT) rsp_data <= mem_rdata;
            else if (nxt == FWD) rsp_data <= hit_data;
            if (pop) begin
                mem_addr  <= head_addr;
                mem_wdata <= head_data;
            end else if (nxt == RD_ADDR) mem_addr <= state == IDLE ? req_addr : addr_q;
        end
    end
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb_cache_mem_ctrl: directed checks of refill, write-back, drain, forwarding/flush and reset
module tb_cache_mem_ctrl;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [4:0] req_addr = '0;
    logic       req_wb = 1'b0;
    logic [4:0] req_wb_addr = '0;
    logic [2:0] req_wb_data = '0;
    logic       rsp_valid;
    logic [2:0] rsp_data;
    logic [4:0] mem_addr;
    logic [2:0] mem_wdata;
    logic       mem_wren;
    logic [2:0] mem_rdata;
    logic [1:0] wbb_count;
    int checks = 0;
    int failures = 0;
    logic [2:0] mem [32];
    logic [7:0] wlog [$];

    cache_mem_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wb      (req_wb),
        .req_wb_addr (req_wb_addr),
        .req_wb_data (req_wb_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wren    (mem_wren),
        .mem_rdata   (mem_rdata),
        .wbb_count   (wbb_count)
    );

    always #5 clock = ~clock;

    // memory model: contents i ^ 6, read data one cycle after the address
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= 3'(i) ^ 3'b110;
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic req(input logic [4:0] a, input logic wb, input logic [4:0] wa, input logic [2:0] wd);
        req_valid   = 1'b1;
        req_addr    = a;
        req_wb      = wb;
        req_wb_addr = wa;
        req_wb_data = wd;
    endtask

    task automatic idle_in;
        req_valid = 1'b0;
        req_wb    = 1'b0;
    endtask

    initial begin
        repeat (3) tick;
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_wren", int'(mem_wren), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wdata", int'(mem_wdata), 0);
        chk("rst_count", int'(wbb_count), 0);
        reset_n = 1'b1;
        tick;
        chk("post_rst_ready", int'(req_ready), 1);

        // clean miss to 19
        req(5'd19, 1'b0, 5'd0, 3'd0);
        tick;
        idle_in;
        chk("clean_addr", int'(mem_addr), 19);
        chk("clean_wren1", int'(mem_wren), 0);
        chk("clean_ready1", int'(req_ready), 0);
        chk("clean_rsp1", int'(rsp_valid), 0);
        tick;
        chk("clean_wren2", int'(mem_wren), 0);
        chk("clean_rsp2", int'(rsp_valid), 0);
        chk("clean_ready2", int'(req_ready), 0);
        tick;
        chk("clean_rsp3", int'(rsp_valid), 1);
        chk("clean_data", int'(rsp_data), 5);
        chk("clean_wren3", int'(mem_wren), 0);
        chk("clean_ready3", int'(req_ready), 0);
        tick;
        chk("clean_rsp4", int'(rsp_valid), 0);
        chk("clean_ready4", int'(req_ready), 1);

        // dirty miss: read 1 first, then victim 25 written back
        req(5'd1, 1'b1, 5'd25, 3'd6);
        tick;
        idle_in;
        chk("dirty_count1", int'(wbb_count), 1);
        chk("dirty_addr", int'(mem_addr), 1);
        chk("dirty_wren1", int'(mem_wren), 0);
        tick;
        tick;
        chk("dirty_rsp", int'(rsp_valid), 1);
        chk("dirty_data", int'(rsp_data), 7);
        tick;
        chk("dirty_wren4", int'(mem_wren), 0);
        chk("dirty_count4", int'(wbb_count), 1);
        tick;
        chk("drain_wren", int'(mem_wren), 1);
        chk("drain_addr", int'(mem_addr), 25);
        chk("drain_wdata", int'(mem_wdata), 6);
        chk("drain_count", int'(wbb_count), 0);
        tick;
        chk("drain_wren_off", int'(mem_wren), 0);
        chk("mem25", int'(mem[25]), 6);

        // full buffer with req_valid held
        req(5'd2, 1'b1, 5'd10, 3'd1);
        tick;
        req(5'd3, 1'b1, 5'd11, 3'd2);
        chk("full_count1", int'(wbb_count), 1);
        tick;
        tick;
        tick;
        chk("full_ready_b", int'(req_ready), 1);
        tick;
        req(5'd4, 1'b0, 5'd0, 3'd0);
        chk("full_count2", int'(wbb_count), 2);
        chk("full_addr_b", int'(mem_addr), 3);
        tick;
        tick;
        chk("full_rsp_b", int'(rsp_valid), 1);
        chk("full_data_b", int'(rsp_data), 5);
        tick;
        chk("full_ready_lo", int'(req_ready), 0);
        chk("full_count_2b", int'(wbb_count), 2);
        tick;
        chk("full_drain_wren", int'(mem_wren), 1);
        chk("full_drain_addr", int'(mem_addr), 10);
        chk("full_drain_wdata", int'(mem_wdata), 1);
        chk("full_drain_count", int'(wbb_count), 1);
        chk("full_drain_ready", int'(req_ready), 0);
        tick;
        chk("full_ready_c", int'(req_ready), 1);
        tick;
        idle_in;
        chk("full_addr_c", int'(mem_addr), 4);
        chk("full_wren_c", int'(mem_wren), 0);
        tick;
        tick;
        chk("full_rsp_c", int'(rsp_valid), 1);
        chk("full_data_c", int'(rsp_data), 2);
        tick;
        tick;
        chk("full_drain2_wren", int'(mem_wren), 1);
        chk("full_drain2_addr", int'(mem_addr), 11);
        chk("full_drain2_wdata", int'(mem_wdata), 2);
        chk("full_drain2_count", int'(wbb_count), 0);
        tick;

        // refill that hits a queued victim (addr 7, data 3)
        req(5'd2, 1'b1, 5'd7, 3'd3);
        tick;
        req(5'd7, 1'b0, 5'd0, 3'd0);
        tick;
        tick;
        chk("hit_pre_rsp", int'(rsp_valid), 1);
        chk("hit_pre_data", int'(rsp_data), 4);
        tick;
        chk("hit_pre_count", int'(wbb_count), 1);
        chk("hit_pre_ready", int'(req_ready), 1);
        tick;
        idle_in;
`ifdef WBB_FWD_EN
        chk("fwd_rsp", int'(rsp_valid), 1);
        chk("fwd_data", int'(rsp_data), 3);
        chk("fwd_count", int'(wbb_count), 1);
        tick;
        chk("fwd_rsp_off", int'(rsp_valid), 0);
        tick;
        chk("fwd_drain_wren", int'(mem_wren), 1);
        chk("fwd_drain_addr", int'(mem_addr), 7);
        chk("fwd_drain_wdata", int'(mem_wdata), 3);
`else
        chk("flush_rsp1", int'(rsp_valid), 0);
        chk("flush_count1", int'(wbb_count), 1);
        chk("flush_wren1", int'(mem_wren), 0);
        tick;
        chk("flush_wren2", int'(mem_wren), 1);
        chk("flush_addr2", int'(mem_addr), 7);
        chk("flush_wdata2", int'(mem_wdata), 3);
        chk("flush_count2", int'(wbb_count), 0);
        tick;
        chk("flush_rd_addr", int'(mem_addr), 7);
        chk("flush_rd_wren", int'(mem_wren), 0);
        tick;
        chk("flush_rsp4", int'(rsp_valid), 0);
        tick;
        chk("flush_rsp5", int'(rsp_valid), 1);
        chk("flush_data5", int'(rsp_data), 3);
`endif
        tick;
        chk("hit_end_count", int'(wbb_count), 0);

        // alternating push/drain: pointers wrap, writes stay in order
        tick;
        wlog.delete();
        for (int k = 0; k < 5; k++) begin
            req(5'(8 + k), 1'b1, 5'(20 + k), 3'(k + 1));
            tick;
            idle_in;
            repeat (5) tick;
        end
        chk("wrap_nwrites", wlog.size(), 5);
        for (int k = 0; k < 5 && k < wlog.size(); k++)
            chk($sformatf("wrap_write%0d", k), int'(wlog[k]), (20 + k) * 8 + k + 1);

        // reset while a read is in flight and a victim is queued
        req(5'd5, 1'b1, 5'd30, 3'd7);
        tick;
        idle_in;
        tick;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rsp", int'(rsp_valid), 0);
        chk("mid_rst_count", int'(wbb_count), 0);
        chk("mid_rst_ready", int'(req_ready), 0);
        chk("mid_rst_wren", int'(mem_wren), 0);
        chk("mid_rst_addr", int'(mem_addr), 0);
        tick;
        tick;
        reset_n = 1'b1;
        tick;
        chk("after_rst_ready", int'(req_ready), 1);
        chk("after_rst_count", int'(wbb_count), 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("after_rst_rsp%0d", k), int'(rsp_valid), 0);
            chk($sformatf("after_rst_wren%0d", k), int'(mem_wren), 0);
            tick;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
